// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - board constants and derived debounce defaults
//
// Purpose: shared board timing constants. The default stability count is
//          derived from the clock rate and the debounce window so top-level
//          instantiations pick up a consistent value; benches override it.
// Contents:
//   CLK_HZ             system clock frequency
//   DEBOUNCE_MS        debounce window in milliseconds
//   STABLE_CYC_DEFAULT cycles a new level must persist before acceptance
//   CNT_W_DEFAULT      counter width able to hold STABLE_CYC_DEFAULT-1

package button_debounce_pkg;

    localparam int CLK_HZ             = 100_000_000;
    localparam int DEBOUNCE_MS        = 10;
    localparam int STABLE_CYC_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int CNT_W_DEFAULT      = $clog2(STABLE_CYC_DEFAULT);

endpackage

// File: rtl/button_debounce_ch.sv
// rtl/button_debounce_ch.sv - single-channel synchroniser and stability debouncer
//
// Purpose: conditions one raw button pin into a clean level plus
//          single-cycle rise/fall pulses.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   btn    in   raw asynchronous button pin
//   level  out  debounced level (registered)
//   rise   out  one-cycle pulse on level 0->1 (registered)
//   fall   out  one-cycle pulse on level 1->0 (registered)

module debounce_ch
    import button_debounce_pkg::*;
#(
    parameter int STABLE_CYC = STABLE_CYC_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                // Any sample agreeing with the current level restarts the count.
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                // This is the STABLE_CYC-th consecutive mismatch: accept it.
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_rise  <= r_sync2;
                r_fall  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - multi-channel push-button debouncer
//
// Purpose: N_BTN independent debounce channels; every output comes straight
//          from a flop inside a channel instance.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   btn    in   [N_BTN-1:0] raw button pins
//   level  out  [N_BTN-1:0] debounced levels
//   rise   out  [N_BTN-1:0] one-cycle rising-edge pulses
//   fall   out  [N_BTN-1:0] one-cycle falling-edge pulses

module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int STABLE_CYC = STABLE_CYC_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] rise,
    output logic [N_BTN-1:0] fall
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_ch #(
            .STABLE_CYC (STABLE_CYC),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn[g]),
            .level (level[g]),
            .rise  (rise[g]),
            .fall  (fall[g])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - self-checking bench for button_debounce

module tb_button_debounce;

    localparam int N_BTN      = 2;
    localparam int STABLE_CYC = 4;
    localparam int CNT_W      = 3;
    localparam int HIST       = STABLE_CYC + 2;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;

    int n_checks;
    int n_pass;

    // Reference: btn samples taken at each edge, newest first.
    logic [N_BTN-1:0] m_hist [HIST];
    logic [N_BTN-1:0] m_level;
    logic [N_BTN-1:0] m_rise;
    logic [N_BTN-1:0] m_fall;

    int n_rise0, n_rise1, n_fall1, n_fall_both;

    button_debounce #(
        .N_BTN      (N_BTN),
        .STABLE_CYC (STABLE_CYC),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < HIST; i++) m_hist[i] = '0;
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
    endtask

    // A level flips on the edge where the synced value has disagreed with it
    // for STABLE_CYC consecutive edges; the synced value seen at an edge is the
    // pin sampled two edges earlier, so the window is samples 2..STABLE_CYC+1.
    task automatic model_edge();
        bit all_diff;
        if (!rst) return;
        for (int i = HIST - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = btn;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < N_BTN; c++) begin
            all_diff = 1'b1;
            for (int k = 2; k < HIST; k++)
                if (m_hist[k][c] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) m_rise[c] = 1'b1;
                else            m_fall[c] = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".level"}, 32'(level), 32'(m_level));
        check({tag, ".rise"},  32'(rise),  32'(m_rise));
        check({tag, ".fall"},  32'(fall),  32'(m_fall));
    endtask

    // Called at a negedge: drive, clock once, check away from the edge.
    task automatic step(input logic [N_BTN-1:0] b, input string tag);
        btn = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
        if (rise[0]) n_rise0++;
        if (rise[1]) n_rise1++;
        if (fall[1]) n_fall1++;
        if (fall == 2'b11) n_fall_both++;
    endtask

    task automatic hold(input logic [N_BTN-1:0] b, input int n, input string tag);
        for (int i = 0; i < n; i++) step(b, tag);
    endtask

    task automatic apply_reset(input int n_cyc, input string tag);
        rst = 1'b0;
        model_clear();
        #1;
        check({tag, ".imm_level"}, 32'(level), 32'h0);
        check({tag, ".imm_rise"},  32'(rise),  32'h0);
        check({tag, ".imm_fall"},  32'(fall),  32'h0);
        @(negedge clk);
        for (int i = 0; i < n_cyc; i++) step(btn, {tag, ".held"});
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        n_rise0 = 0; n_rise1 = 0; n_fall1 = 0; n_fall_both = 0;
        rst = 1'b1;
        btn = '0;
        model_clear();
        repeat (2) @(negedge clk);

        // 1. reset with both buttons pressed
        btn = 2'b11;
        apply_reset(3, "t1_reset");
        @(negedge clk);
        // the negedge wait above was one unmodelled edge with rst=1: resync model
        // by re-entering reset cleanly before the timed tests
        btn = 2'b00;
        apply_reset(2, "t1_rst2");

        // 2. btn[0] press held 12 cycles
        n_rise0 = 0;
        hold(2'b01, 12, "t2_press");
        check("t2_rise0_count", 32'(n_rise0), 32'd1);
        check("t2_level", 32'(level), 32'h1);

        // 3. release, then bouncing press
        hold(2'b00, 8, "t3_release");
        n_rise0 = 0;
        step(2'b01, "t3_b"); step(2'b00, "t3_b"); step(2'b01, "t3_b");
        step(2'b00, "t3_b"); step(2'b01, "t3_b");
        hold(2'b01, 10, "t3_hold");
        check("t3_rise0_count", 32'(n_rise0), 32'd1);

        // 4. short glitch on btn[1]
        n_rise1 = 0; n_fall1 = 0;
        hold(2'b11, 3, "t4_glitch");
        hold(2'b01, 8, "t4_after");
        check("t4_rise1_count", 32'(n_rise1), 32'd0);
        check("t4_fall1_count", 32'(n_fall1), 32'd0);
        check("t4_level1", 32'(level[1]), 32'd0);

        // 5. both pressed, then released together
        hold(2'b11, 8, "t5_press");
        n_fall_both = 0; n_rise0 = 0; n_rise1 = 0;
        hold(2'b00, 8, "t5_release");
        check("t5_fall_both", 32'(n_fall_both), 32'd1);
        check("t5_level", 32'(level), 32'h0);
        check("t5_no_rise", 32'(n_rise0 + n_rise1), 32'd0);

        // 6. reset mid-count with btn[0] held
        hold(2'b01, 4, "t6_count");
        apply_reset(2, "t6_reset");
        n_rise0 = 0;
        hold(2'b01, 10, "t6_after");
        check("t6_rise0_count", 32'(n_rise0), 32'd1);

        // randomized bouncing segments against the reference model
        for (int s = 0; s < 120; s++) begin
            logic [N_BTN-1:0] v;
            int len;
            v   = N_BTN'($urandom);
            len = $urandom_range(1, 7);
            hold(v, len, "rand");
        end
        hold(2'b11, 10, "rand_settle");
        n_rise0 = 0; n_rise1 = 0;
        hold(2'b11, 10, "rand_const");
        check("const_no_pulse", 32'(n_rise0 + n_rise1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // The extra negedge in test 1 lets one edge pass with rst=1 while the
    // model was idle; the second reset that follows discards it completely.

endmodule
